icache_assoc: RTL and testbench

Parametrised N-way set-associative instruction cache with its own line-fill controller and flush sequencer. It sits between the fetch stage and the instruction memory port. Hits are answered combinationally. A miss stalls fetch while a full line is fetched word by word over a request/acknowledge handshake. A flush request invalidates every line with a sequential sweep.

---
 rtl/icache_assoc.sv | 143 ++++++++++++++
 tb/tb_icache_assoc.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/icache_assoc.sv
// N-way set-associative instruction cache with a word-by-word line-fill controller
// and a one-set-per-cycle flush sweep. Hits are answered combinationally from IDLE.
module icache_assoc #(
   parameter int CACHE_WAYS     = 2,
   parameter int CACHE_BLOCKS   = 4,
   parameter int CACHE_ELEMENTS = 128
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic [31:0] i_addr,
   input  logic        i_rd,
   input  logic        i_cl,
   output logic [31:0] o_inst,
   output logic        o_hit,
   output logic        o_busy,
   output logic [31:0] o_mem_addr,
   output logic        o_mem_rd,
   input  logic        i_mem_ack,
   input  logic [31:0] i_mem_inst
);

   localparam int BLOCK_WIDTH = $clog2(CACHE_BLOCKS);
   localparam int INDEX_WIDTH = $clog2(CACHE_ELEMENTS);
   localparam int LOW_WIDTH   = BLOCK_WIDTH + INDEX_WIDTH;
   localparam int TAG_WIDTH   = 32 - LOW_WIDTH;
   localparam int CNT_WIDTH   = (BLOCK_WIDTH > 0) ? BLOCK_WIDTH : 1;
   localparam int WAY_WIDTH   = (CACHE_WAYS > 1) ? $clog2(CACHE_WAYS) : 1;
   localparam int WORDS       = CACHE_ELEMENTS * CACHE_BLOCKS;

   typedef enum logic [1:0] {IDLE, FILL, FLUSH} state_t;

   state_t                 state_q;
   logic [CACHE_WAYS-1:0]  valid_q [CACHE_ELEMENTS];
   logic [TAG_WIDTH-1:0]   tag_q   [CACHE_WAYS][CACHE_ELEMENTS];
   logic [31:0]            data_q  [CACHE_WAYS][WORDS];
   logic [WAY_WIDTH-1:0]   rr_q    [CACHE_ELEMENTS];
   logic [TAG_WIDTH-1:0]   fill_tag_q;
   logic [INDEX_WIDTH-1:0] fill_index_q;
   logic [CNT_WIDTH-1:0]   cnt_q;
   logic [WAY_WIDTH-1:0]   victim_q;
   logic                   pend_q;
   logic                   mem_rd_q;
   logic [INDEX_WIDTH-1:0] sweep_q;

   logic [TAG_WIDTH-1:0]   lk_tag;
   logic [INDEX_WIDTH-1:0] lk_index;
   logic [LOW_WIDTH-1:0]   lk_word;
   logic [LOW_WIDTH-1:0]   fill_word;
   logic [CACHE_WAYS-1:0]  match;
   logic [WAY_WIDTH-1:0]   hit_way;
   logic [WAY_WIDTH-1:0]   victim_d;
   logic                   fill_ack;
   logic                   last_ack;

   assign lk_tag   = i_addr[31:LOW_WIDTH];
   assign lk_index = i_addr[LOW_WIDTH-1:BLOCK_WIDTH];
   assign lk_word  = i_addr[LOW_WIDTH-1:0];

   if (BLOCK_WIDTH > 0) begin : g_blk
      assign fill_word = {fill_index_q, cnt_q};
   end else begin : g_noblk
      assign fill_word = fill_index_q;
   end

   // Descending scan: the last assignment wins, so victim_d is the lowest invalid way.
   always_comb begin
      match    = '0;
      hit_way  = '0;
      victim_d = rr_q[lk_index];
      for (int w = CACHE_WAYS - 1; w >= 0; w--) begin
         match[w] = valid_q[lk_index][w] && (tag_q[w][lk_index] == lk_tag);
         if (match[w]) hit_way = WAY_WIDTH'(w);
         if (!valid_q[lk_index][w]) victim_d = WAY_WIDTH'(w);
      end
   end

   assign fill_ack   = (state_q == FILL) && i_mem_ack;
   assign last_ack   = fill_ack && (cnt_q == CNT_WIDTH'(CACHE_BLOCKS - 1));
   assign o_hit      = (state_q == IDLE) && i_rd && (|match) && !i_reset;
   assign o_inst     = data_q[hit_way][lk_word];
   assign o_busy     = (state_q != IDLE);
   assign o_mem_rd   = mem_rd_q;
   assign o_mem_addr = {fill_tag_q, fill_word};

   // Tag and data storage carry no reset; a line only becomes visible via its valid bit.
   always_ff @(posedge i_clock) begin
      if (fill_ack) data_q[victim_q][fill_word] <= i_mem_inst;
      if (last_ack) tag_q[victim_q][fill_index_q] <= fill_tag_q;
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q      <= IDLE;
         pend_q       <= 1'b0;
         mem_rd_q     <= 1'b0;
         fill_tag_q   <= '0;
         fill_index_q <= '0;
         cnt_q        <= '0;
         victim_q     <= '0;
         sweep_q      <= '0;
         for (int s = 0; s < CACHE_ELEMENTS; s++) begin
            valid_q[s] <= '0;
            rr_q[s]    <= '0;
         end
      end else begin
         case (state_q)
            IDLE: begin
               if (i_cl) begin
                  state_q <= FLUSH;
                  sweep_q <= '0;
               end else if (i_rd && !(|match)) begin
                  state_q                     <= FILL;
                  mem_rd_q                    <= 1'b1;
                  fill_tag_q                  <= lk_tag;
                  fill_index_q                <= lk_index;
                  victim_q                    <= victim_d;
                  cnt_q                       <= '0;
                  valid_q[lk_index][victim_d] <= 1'b0;
               end
            end
            FILL: begin
               if (i_cl) pend_q <= 1'b1;
               if (i_mem_ack) cnt_q <= cnt_q + 1'b1;
               if (last_ack) begin
                  valid_q[fill_index_q][victim_q] <= 1'b1;
                  rr_q[fill_index_q] <= (CACHE_WAYS > 1) ? rr_q[fill_index_q] + 1'b1 : '0;
                  mem_rd_q <= 1'b0;
                  pend_q   <= 1'b0;
                  sweep_q  <= '0;
                  state_q  <= (pend_q || i_cl) ? FLUSH : IDLE;
               end
            end
            FLUSH: begin
               valid_q[sweep_q] <= '0;
               sweep_q          <= sweep_q + 1'b1;
               if (sweep_q == INDEX_WIDTH'(CACHE_ELEMENTS - 1)) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc: a 2-way and a 1-way build share one stimulus bus,
// and sel chooses which instance's outputs the scenario tasks observe.
module tb_icache_assoc;

   logic        clk = 1'b0;
   logic        rst, rd, cl, ack, sel;
   logic [31:0] addr, minst;
   logic [31:0] inst2, inst1, maddr2, maddr1, inst, maddr;
   logic        hit2, hit1, busy2, busy1, mrd2, mrd1, hit, busy, mrd;
   int          total = 0;
   int          bad   = 0;

   always #5 clk = ~clk;

   icache_assoc #(.CACHE_WAYS(2), .CACHE_BLOCKS(4), .CACHE_ELEMENTS(8)) u_dut2 (
      .i_clock(clk), .i_reset(rst), .i_addr(addr), .i_rd(rd), .i_cl(cl),
      .o_inst(inst2), .o_hit(hit2), .o_busy(busy2), .o_mem_addr(maddr2),
      .o_mem_rd(mrd2), .i_mem_ack(ack), .i_mem_inst(minst));

   icache_assoc #(.CACHE_WAYS(1), .CACHE_BLOCKS(4), .CACHE_ELEMENTS(8)) u_dut1 (
      .i_clock(clk), .i_reset(rst), .i_addr(addr), .i_rd(rd), .i_cl(cl),
      .o_inst(inst1), .o_hit(hit1), .o_busy(busy1), .o_mem_addr(maddr1),
      .o_mem_rd(mrd1), .i_mem_ack(ack), .i_mem_inst(minst));

   assign hit   = sel ? hit1   : hit2;
   assign inst  = sel ? inst1  : inst2;
   assign busy  = sel ? busy1  : busy2;
   assign maddr = sel ? maddr1 : maddr2;
   assign mrd   = sel ? mrd1   : mrd2;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1; rd = 1'b0; cl = 1'b0; ack = 1'b0;
      tick;
      tick;
      rst = 1'b0;
   endtask

   // Miss on a, fill acked every period-th cycle with base+k, then the held fetch must hit.
   task automatic do_miss(input logic [31:0] a, input logic [31:0] base, input int period,
                          input string nm);
      int k = 0;
      int c = 0;
      tick;
      rd = 1'b1; addr = a; ack = 1'b0;
      #1;
      total++;
      if (hit !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL %s_miss: hit=%b busy=%b required hit=0 busy=0", nm, hit, busy);
      end
      while (k < 4 && c < 100) begin
         tick;
         c++;
         ack = 1'b0;
         #1;
         total++;
         if (busy !== 1'b1 || mrd !== 1'b1 || maddr !== (a & 32'hFFFF_FFFC) + 32'(k)) begin
            bad++;
            $display("FAIL %s_fill c%0d: busy=%b mem_rd=%b mem_addr=%h required 1 1 %h",
                     nm, c, busy, mrd, maddr, (a & 32'hFFFF_FFFC) + 32'(k));
         end
         if (c % period == 0) begin
            ack = 1'b1; minst = base + 32'(k); k++;
         end
      end
      tick;
      ack = 1'b0;
      #1;
      total++;
      if (c !== 4 * period || busy !== 1'b0 || hit !== 1'b1 || inst !== base + (a & 32'h3)) begin
         bad++;
         $display("FAIL %s_done: fill_cycles=%0d busy=%b hit=%b inst=%h required %0d 0 1 %h",
                  nm, c, busy, hit, inst, 4 * period, base + (a & 32'h3));
      end
      rd = 1'b0;
   endtask

   task automatic check_hit(input logic [31:0] a, input logic [31:0] exp, input string nm);
      tick;
      rd = 1'b1; addr = a;
      #1;
      total++;
      if (hit !== 1'b1 || inst !== exp) begin
         bad++;
         $display("FAIL %s: hit=%b inst=%h required hit=1 inst=%h", nm, hit, inst, exp);
      end
      rd = 1'b0;
   endtask

   task automatic count_busy(input int exp, input string nm);
      int n = 0;
      while (busy === 1'b1 && n < 50) begin
         if (mrd !== 1'b0) begin
            total++; bad++;
            $display("FAIL %s_memrd: mem_rd=%b required 0 during flush", nm, mrd);
         end
         n++;
         tick;
         #1;
      end
      total++;
      if (n !== exp) begin
         bad++;
         $display("FAIL %s: busy_cycles=%0d required %0d", nm, n, exp);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; rd = 1'b1; cl = 1'b0; ack = 1'b0; addr = 32'h0; minst = 32'h0;
      tick;
      tick;
      #1;
      total++;
      if (hit !== 1'b0 || busy !== 1'b0 || mrd !== 1'b0 || maddr !== 32'h0) begin
         bad++;
         $display("FAIL reset: hit=%b busy=%b mem_rd=%b mem_addr=%h required 0 0 0 0",
                  hit, busy, mrd, maddr);
      end
      rst = 1'b0; rd = 1'b0;
   endtask

   task automatic test_cold_miss;
      do_reset;
      do_miss(32'h40, 32'h100, 1, "cold");
      check_hit(32'h42, 32'h102, "cold_follow");
   endtask

   task automatic test_replacement;
      do_reset;
      do_miss(32'h00, 32'h200, 1, "repl_a");
      do_miss(32'h20, 32'h300, 1, "repl_b");
      do_miss(32'h40, 32'hD00, 1, "repl_c");
      check_hit(32'h21, 32'h301, "repl_b_kept");
      check_hit(32'h43, 32'hD03, "repl_c_hit");
      do_miss(32'h00, 32'hE00, 1, "repl_a_again");
      check_hit(32'h40, 32'hD00, "repl_c_kept");
      do_miss(32'h20, 32'hF00, 1, "repl_b_evicted");
   endtask

   task automatic test_wait_states;
      do_reset;
      do_miss(32'h10, 32'h400, 3, "wait");
      check_hit(32'h13, 32'h403, "wait_follow");
   endtask

   task automatic test_flush_during_fill;
      do_reset;
      tick;
      rd = 1'b1; addr = 32'h40;
      for (int c = 1; c <= 4; c++) begin
         tick;
         cl = (c == 2); ack = 1'b1; minst = 32'h500 + 32'(c - 1);
      end
      tick;
      cl = 1'b0; ack = 1'b0;
      #1;
      total++;
      if (busy !== 1'b1 || hit !== 1'b0) begin
         bad++;
         $display("FAIL flush_fill_enter: busy=%b hit=%b required busy=1 hit=0", busy, hit);
      end
      rd = 1'b0;
      count_busy(8, "flush_fill_len");
      do_miss(32'h40, 32'h600, 1, "flush_fill_after");
   endtask

   task automatic test_flush_idle;
      do_reset;
      do_miss(32'h00, 32'h700, 1, "flush_idle_pre");
      tick;
      cl = 1'b1; rd = 1'b1; addr = 32'h60;
      tick;
      cl = 1'b0; rd = 1'b0;
      #1;
      count_busy(8, "flush_idle_len");
      do_miss(32'h00, 32'h800, 1, "flush_idle_after");
   endtask

   task automatic test_reset_mid_fill;
      do_reset;
      tick;
      rd = 1'b1; addr = 32'h60;
      tick;
      ack = 1'b1; minst = 32'h111;
      tick;
      rst = 1'b1; ack = 1'b1; minst = 32'h222;
      tick;
      rst = 1'b0; ack = 1'b0; rd = 1'b0;
      #1;
      total++;
      if (mrd !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid_fill: mem_rd=%b busy=%b required 0 0", mrd, busy);
      end
      do_miss(32'h60, 32'h900, 1, "reset_refill");
   endtask

   task automatic test_one_way;
      sel = 1'b1;
      do_reset;
      do_miss(32'h00, 32'hA00, 1, "way1_a");
      do_miss(32'h20, 32'hB00, 1, "way1_b");
      do_miss(32'h00, 32'hC00, 1, "way1_a_evicted");
      sel = 1'b0;
   endtask

   initial begin
      sel = 1'b0; rst = 1'b1; rd = 1'b0; cl = 1'b0; ack = 1'b0;
      addr = 32'h0; minst = 32'h0;
      test_reset;
      test_cold_miss;
      test_replacement;
      test_wait_states;
      test_flush_during_fill;
      test_flush_idle;
      test_reset_mid_fill;
      test_one_way;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
